// File: rtl/fft_spec_peak.sv
// FFT output post-processor: per-bin approximate magnitude for the lower half-spectrum,
// streamed to a result RAM, plus a descending-sorted table of the largest bins.
module fft_spec_peak #(
    parameter int DATA_WIDTH = 32,
    parameter int MAG_WIDTH  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_PEAKS  = 4,
    parameter int MAG_MODE   = 0,
    parameter int MAG_SHIFT  = 0,
    parameter int SKIP_DC    = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            bin_valid,
    input  logic [ADDR_WIDTH-1:0]           bin_idx,
    input  logic signed [DATA_WIDTH-1:0]    bin_re,
    input  logic signed [DATA_WIDTH-1:0]    bin_im,
    output logic                            mag_wen,
    output logic [ADDR_WIDTH-2:0]           mag_waddr,
    output logic [MAG_WIDTH-1:0]            mag_wdata,
    output logic                            busy,
    output logic                            done,
    output logic [NUM_PEAKS*ADDR_WIDTH-1:0] peak_idx,
    output logic [NUM_PEAKS*MAG_WIDTH-1:0]  peak_mag,
    output logic [NUM_PEAKS-1:0]            peak_vld
);

    localparam int XW = (DATA_WIDTH + 1 > MAG_WIDTH) ? DATA_WIDTH + 1 : MAG_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // |v| with the most negative value clamped to the most positive one
    function automatic logic [DATA_WIDTH-2:0] abs_sat(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-2:0] neg;
        neg = ~v[DATA_WIDTH-2:0] + {{(DATA_WIDTH-2){1'b0}}, 1'b1};
        if (v == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            abs_sat = {(DATA_WIDTH-1){1'b1}};
        end else if (v[DATA_WIDTH-1]) begin
            abs_sat = neg;
        end else begin
            abs_sat = v[DATA_WIDTH-2:0];
        end
    endfunction

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   cnt_r;
    logic                    flush_r;
    logic                    busy_r, done_r;
    logic                    accept_s, last_s;

    logic                    s1_vld_r;
    logic [DATA_WIDTH-2:0]   s1_re_r, s1_im_r;
    logic [ADDR_WIDTH-2:0]   s1_idx_r;
    logic [DATA_WIDTH-2:0]   big_s, small_s;
    logic [DATA_WIDTH:0]     raw_s;
    logic [XW-1:0]           shf_s;
    logic [MAG_WIDTH-1:0]    sat_s;

    logic                    mag_wen_r;
    logic [ADDR_WIDTH-2:0]   mag_waddr_r;
    logic [MAG_WIDTH-1:0]    mag_wdata_r;

    logic [ADDR_WIDTH-1:0]   pk_idx_r [NUM_PEAKS];
    logic [MAG_WIDTH-1:0]    pk_mag_r [NUM_PEAKS];
    logic [NUM_PEAKS-1:0]    pk_vld_r;
    logic [ADDR_WIDTH-1:0]   pk_idx_s [NUM_PEAKS];
    logic [MAG_WIDTH-1:0]    pk_mag_s [NUM_PEAKS];
    logic [NUM_PEAKS-1:0]    pk_vld_s;
    logic                    ins_found_s, ins_en_s;
    int                      ins_pos_s;
    logic [ADDR_WIDTH-1:0]   new_idx_s;

    // A start pulse always wins over a coincident beat
    assign accept_s = bin_valid && (state_r == ST_COLLECT) && !start;
    assign last_s   = accept_s && (cnt_r == {ADDR_WIDTH{1'b1}});

    // Next-state logic
    always_comb begin
        state_s = state_r;
        if (start) begin
            state_s = ST_COLLECT;
        end else begin
            case (state_r)
                ST_IDLE:    state_s = ST_IDLE;
                ST_COLLECT: state_s = last_s ? ST_FLUSH : ST_COLLECT;
                ST_FLUSH:   state_s = flush_r ? ST_DONE : ST_FLUSH;
                ST_DONE:    state_s = ST_IDLE;
                default:    state_s = ST_IDLE;
            endcase
        end
    end

    // FSM state, beat counter, two-cycle flush timer and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {ADDR_WIDTH{1'b0}};
            flush_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start) begin
                cnt_r <= {ADDR_WIDTH{1'b0}};
            end else if (accept_s) begin
                cnt_r <= cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            if ((state_r == ST_FLUSH) && !start) begin
                flush_r <= !flush_r;
            end else begin
                flush_r <= 1'b0;
            end
            busy_r <= (state_s == ST_COLLECT) || (state_s == ST_FLUSH);
            done_r <= (state_s == ST_DONE);
        end
    end

    // Stage 1: absolute values of lower-half bins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_r <= 1'b0;
            s1_re_r  <= {(DATA_WIDTH-1){1'b0}};
            s1_im_r  <= {(DATA_WIDTH-1){1'b0}};
            s1_idx_r <= {(ADDR_WIDTH-1){1'b0}};
        end else begin
            s1_vld_r <= accept_s && !bin_idx[ADDR_WIDTH-1];
            s1_re_r  <= abs_sat(bin_re);
            s1_im_r  <= abs_sat(bin_im);
            s1_idx_r <= bin_idx[ADDR_WIDTH-2:0];
        end
    end

    // Magnitude estimate, scaling and saturation
    always_comb begin
        if (s1_re_r >= s1_im_r) begin
            big_s   = s1_re_r;
            small_s = s1_im_r;
        end else begin
            big_s   = s1_im_r;
            small_s = s1_re_r;
        end
        if (MAG_MODE == 1) begin
            raw_s = {2'b00, s1_re_r} + {2'b00, s1_im_r};
        end else begin
            raw_s = {2'b00, big_s} + {2'b00, small_s >> 2};
        end
        shf_s = XW'(raw_s >> MAG_SHIFT);
        if (shf_s > XW'({MAG_WIDTH{1'b1}})) begin
            sat_s = {MAG_WIDTH{1'b1}};
        end else begin
            sat_s = shf_s[MAG_WIDTH-1:0];
        end
    end

    // Stage 2: result-RAM write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_wen_r   <= 1'b0;
            mag_waddr_r <= {(ADDR_WIDTH-1){1'b0}};
            mag_wdata_r <= {MAG_WIDTH{1'b0}};
        end else begin
            mag_wen_r   <= s1_vld_r && !start;
            mag_waddr_r <= s1_idx_r;
            mag_wdata_r <= sat_s;
        end
    end

    // Sorted insert: strict compare keeps earlier bins above equal later ones
    always_comb begin
        ins_found_s = 1'b0;
        ins_pos_s   = 0;
        for (int k = 0; k < NUM_PEAKS; k++) begin
            if (!ins_found_s && (!pk_vld_r[k] || (mag_wdata_r > pk_mag_r[k]))) begin
                ins_found_s = 1'b1;
                ins_pos_s   = k;
            end else begin
                ins_found_s = ins_found_s;
            end
        end
        ins_en_s  = mag_wen_r && ins_found_s &&
                    !((SKIP_DC != 0) && (mag_waddr_r == {(ADDR_WIDTH-1){1'b0}}));
        new_idx_s = {1'b0, mag_waddr_r};
        pk_idx_s[0] = (ins_en_s && (ins_pos_s == 0)) ? new_idx_s   : pk_idx_r[0];
        pk_mag_s[0] = (ins_en_s && (ins_pos_s == 0)) ? mag_wdata_r : pk_mag_r[0];
        pk_vld_s[0] = (ins_en_s && (ins_pos_s == 0)) ? 1'b1        : pk_vld_r[0];
        for (int k = 1; k < NUM_PEAKS; k++) begin
            if (ins_en_s && (ins_pos_s == k)) begin
                pk_idx_s[k] = new_idx_s;
                pk_mag_s[k] = mag_wdata_r;
                pk_vld_s[k] = 1'b1;
            end else if (ins_en_s && (ins_pos_s < k)) begin
                pk_idx_s[k] = pk_idx_r[k-1];
                pk_mag_s[k] = pk_mag_r[k-1];
                pk_vld_s[k] = pk_vld_r[k-1];
            end else begin
                pk_idx_s[k] = pk_idx_r[k];
                pk_mag_s[k] = pk_mag_r[k];
                pk_vld_s[k] = pk_vld_r[k];
            end
        end
    end

    // Peak table registers, cleared by every start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PEAKS; k++) begin
                pk_idx_r[k] <= {ADDR_WIDTH{1'b0}};
                pk_mag_r[k] <= {MAG_WIDTH{1'b0}};
            end
            pk_vld_r <= {NUM_PEAKS{1'b0}};
        end else if (start) begin
            for (int k = 0; k < NUM_PEAKS; k++) begin
                pk_idx_r[k] <= {ADDR_WIDTH{1'b0}};
                pk_mag_r[k] <= {MAG_WIDTH{1'b0}};
            end
            pk_vld_r <= {NUM_PEAKS{1'b0}};
        end else begin
            for (int k = 0; k < NUM_PEAKS; k++) begin
                pk_idx_r[k] <= pk_idx_s[k];
                pk_mag_r[k] <= pk_mag_s[k];
            end
            pk_vld_r <= pk_vld_s;
        end
    end

    for (genvar g = 0; g < NUM_PEAKS; g++) begin : g_pack
        assign peak_idx[g*ADDR_WIDTH +: ADDR_WIDTH] = pk_idx_r[g];
        assign peak_mag[g*MAG_WIDTH +: MAG_WIDTH]   = pk_mag_r[g];
    end

    assign peak_vld  = pk_vld_r;
    assign mag_wen   = mag_wen_r;
    assign mag_waddr = mag_waddr_r;
    assign mag_wdata = mag_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_fft_spec_peak.sv
// Scoreboard bench: two instances (max+min/4 at 16 bits, |re|+|im| at 18 bits) share the stimulus;
// expected writes and frame results are queued at issue time and popped by a negedge monitor.
module tb_fft_spec_peak;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [7:0]  pi;
        logic [31:0] pm;
        logic [1:0]  pv;
    } dn_t;

    logic clk, rst_n, start, bin_valid;
    logic [3:0] bin_idx;
    logic signed [15:0] bin_re0, bin_im0;
    logic signed [17:0] bin_re1, bin_im1;

    logic mag_wen0, busy0, done0, mag_wen1, busy1, done1;
    logic [2:0] mag_waddr0, mag_waddr1;
    logic [15:0] mag_wdata0, mag_wdata1;
    logic [7:0] peak_idx0, peak_idx1;
    logic [31:0] peak_mag0, peak_mag1;
    logic [1:0] peak_vld0, peak_vld1;

    wr_t q0[$];
    wr_t q1[$];
    dn_t dq[$];
    int cyc = 0;
    int n_cmp, n_err;
    int re_t[16], im_t[16], e0_t[16], e1_t[16];

    fft_spec_peak #(.DATA_WIDTH(16), .MAG_WIDTH(16), .ADDR_WIDTH(4), .NUM_PEAKS(2),
                    .MAG_MODE(0), .MAG_SHIFT(0), .SKIP_DC(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_valid(bin_valid), .bin_idx(bin_idx),
        .bin_re(bin_re0), .bin_im(bin_im0), .mag_wen(mag_wen0), .mag_waddr(mag_waddr0),
        .mag_wdata(mag_wdata0), .busy(busy0), .done(done0), .peak_idx(peak_idx0),
        .peak_mag(peak_mag0), .peak_vld(peak_vld0));

    fft_spec_peak #(.DATA_WIDTH(18), .MAG_WIDTH(16), .ADDR_WIDTH(4), .NUM_PEAKS(2),
                    .MAG_MODE(1), .MAG_SHIFT(0), .SKIP_DC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_valid(bin_valid), .bin_idx(bin_idx),
        .bin_re(bin_re1), .bin_im(bin_im1), .mag_wen(mag_wen1), .mag_waddr(mag_waddr1),
        .mag_wdata(mag_wdata1), .busy(busy1), .done(done1), .peak_idx(peak_idx1),
        .peak_mag(peak_mag1), .peak_vld(peak_vld1));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wen"}, {62'd0, mag_wen0, mag_wen1}, 64'd0);
        check({tag, "_wdata"}, {32'd0, mag_wdata0, mag_wdata1}, 64'd0);
        check({tag, "_busy_done"}, {60'd0, busy0, busy1, done0, done1}, 64'd0);
        check({tag, "_peak_idx"}, {48'd0, peak_idx0, peak_idx1}, 64'd0);
        check({tag, "_peak_mag"}, {peak_mag0, peak_mag1}, 64'd0);
        check({tag, "_peak_vld"}, {60'd0, peak_vld0, peak_vld1}, 64'd0);
    endtask

    task automatic monitor_step();
        wr_t e;
        dn_t d;
        if (rst_n) begin
            if (mag_wen0) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL wr0_unexpected: got addr %0d data %0d, none expected (cycle %0d)",
                             mag_waddr0, mag_wdata0, cyc);
                end else begin
                    e = q0.pop_front();
                    check("wr0_addr", 64'(mag_waddr0), 64'(e.addr));
                    check("wr0_data", 64'(mag_wdata0), 64'(e.data));
                    check("wr0_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (mag_wen1) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL wr1_unexpected: got addr %0d data %0d, none expected (cycle %0d)",
                             mag_waddr1, mag_wdata1, cyc);
                end else begin
                    e = q1.pop_front();
                    check("wr1_addr", 64'(mag_waddr1), 64'(e.addr));
                    check("wr1_data", 64'(mag_wdata1), 64'(e.data));
                    check("wr1_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (done0) begin
                if (dq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL done_unexpected: got done=1, none expected (cycle %0d)", cyc);
                end else begin
                    d = dq.pop_front();
                    check("done_cycle", 64'(cyc), 64'(d.cyc));
                    check("done1_together", 64'(done1), 64'd1);
                    check("peak_idx", 64'(peak_idx0), 64'(d.pi));
                    check("peak_mag", 64'(peak_mag0), 64'(d.pm));
                    check("peak_vld", 64'(peak_vld0), 64'(d.pv));
                end
            end
        end
    endtask

    task automatic beat(input int idx, input int re, input int im, input int e0, input int e1);
        wr_t w;
        @(posedge clk); #1;
        start     = 1'b0;
        bin_valid = 1'b1;
        bin_idx   = idx[3:0];
        bin_re0   = re[15:0];
        bin_im0   = im[15:0];
        bin_re1   = re[17:0];
        bin_im1   = im[17:0];
        if (idx < 8) begin
            w.addr = idx; w.data = e0; w.cyc = cyc + 2;
            q0.push_back(w);
            w.data = e1;
            q1.push_back(w);
        end
    endtask

    task automatic run_frame(input logic [7:0] pi, input logic [31:0] pm, input logic [1:0] pv);
        dn_t d;
        @(posedge clk); #1;
        start = 1'b1;
        bin_valid = 1'b0;
        for (int i = 0; i < 16; i++) beat(i, re_t[i], im_t[i], e0_t[i], e1_t[i]);
        d.cyc = cyc + 3; d.pi = pi; d.pm = pm; d.pv = pv;
        dq.push_back(d);
        @(posedge clk); #1;
        bin_valid = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 16; i++) begin
            re_t[i] = 0; im_t[i] = 0; e0_t[i] = 0; e1_t[i] = 0;
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; bin_valid = 1'b0; bin_idx = 4'd0;
        bin_re0 = 16'sd0; bin_im0 = 16'sd0; bin_re1 = 18'sd0; bin_im1 = 18'sd0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (3) @(posedge clk); #1;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Ramp: writes for bins 0..7 only; two largest are 7 and 6
        for (int i = 0; i < 16; i++) begin
            re_t[i] = i * 10; im_t[i] = 0; e0_t[i] = i * 10; e1_t[i] = i * 10;
        end
        run_frame({4'd6, 4'd7}, {16'd60, 16'd70}, 2'b11);

        // Magnitude corners; dut0 sees the low 16 bits of the 18-bit values
        clear_tables();
        re_t[0] = -300;    im_t[0] = 100;     e0_t[0] = 325;   e1_t[0] = 400;
        re_t[1] = -32768;  im_t[1] = -32768;  e0_t[1] = 40958; e1_t[1] = 65535;
        re_t[2] = 20000;   im_t[2] = 20000;   e0_t[2] = 25000; e1_t[2] = 40000;
        re_t[3] = 32767;   im_t[3] = 32767;   e0_t[3] = 40958; e1_t[3] = 65534;
        re_t[4] = 65535;   im_t[4] = 65535;   e0_t[4] = 1;     e1_t[4] = 65535;
        re_t[5] = -131072; im_t[5] = 0;       e0_t[5] = 0;     e1_t[5] = 65535;
        re_t[6] = 0;       im_t[6] = -5;      e0_t[6] = 5;     e1_t[6] = 5;
        re_t[7] = 7;       im_t[7] = 8;       e0_t[7] = 9;     e1_t[7] = 15;
        run_frame({4'd3, 4'd1}, {16'd40958, 16'd40958}, 2'b11);

        // Ties keep arrival order; DC is written but kept out of the table
        clear_tables();
        re_t[0] = 9999; e0_t[0] = 9999; e1_t[0] = 9999;
        re_t[2] = 500;  e0_t[2] = 500;  e1_t[2] = 500;
        re_t[5] = 500;  e0_t[5] = 500;  e1_t[5] = 500;
        run_frame({4'd5, 4'd2}, {16'd500, 16'd500}, 2'b11);

        // Aborted frame: five large beats, then a restart with a fresh full frame
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 5; i++) beat(i, 1000 * (i + 1), 0, 1000 * (i + 1), 1000 * (i + 1));
        @(posedge clk); #1;
        bin_valid = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            re_t[i] = (15 - i) * 10; im_t[i] = 0; e0_t[i] = (15 - i) * 10; e1_t[i] = (15 - i) * 10;
        end
        run_frame({4'd2, 4'd1}, {16'd130, 16'd140}, 2'b11);

        // Asynchronous reset in the middle of a frame
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 6; i++) beat(i, 100 * (i + 1), 0, 100 * (i + 1), 100 * (i + 1));
        @(posedge clk); #1;
        check("busy_mid_frame", 64'(busy0), 64'd1);
        check("peak_vld_mid_frame", 64'(peak_vld0), 64'd3);
        bin_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;

        // Beats without start must be ignored
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bin_valid = 1'b1;
            bin_idx   = i[3:0];
            bin_re0   = 16'sd50;
            bin_re1   = 18'sd50;
            check("busy_no_start", {62'd0, busy0, busy1}, 64'd0);
        end
        @(posedge clk); #1;
        bin_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("busy_idle", {62'd0, busy0, busy1}, 64'd0);
        check("peak_vld_idle", {60'd0, peak_vld0, peak_vld1}, 64'd0);

        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("done_drained", 64'(dq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
